// File: rtl/an_pkg.sv
// Shared constants and elaboration-time helpers for the A=13 AN-code decoder.
// The residue->bit LUT is built once from A and CW, so retargeting A only touches this file.
package an_pkg;

  localparam int AN_A  = 13;
  localparam int AN_CW = 12;
  localparam int AN_DW = 8;
  localparam int AN_RW = $clog2(AN_A);
  localparam int AN_PW = $clog2(AN_CW);

  typedef struct packed {
    logic             hit;
    logic [AN_PW-1:0] pos;
  } lut_ent_t;

  typedef lut_ent_t [2**AN_RW-1:0] lut_t;

  function automatic int pow2_mod(input int i, input int a);
    int r;
    r = 1 % a;
    for (int k = 0; k < i; k++) r = (r * 2) % a;
    return r;
  endfunction

  // Residues that no single bit can produce keep hit=0 and decode as uncorrectable.
  function automatic lut_t build_lut();
    lut_t t;
    t = '0;
    for (int i = 0; i < AN_CW; i++) begin
      t[pow2_mod(i, AN_A)].hit = 1'b1;
      t[pow2_mod(i, AN_A)].pos = AN_PW'(i);
    end
    return t;
  endfunction

  localparam lut_t AN_LUT = build_lut();

endpackage

// File: rtl/an_residue_mod.sv
// Combinational CW-bit mod-A reducer: sums per-bit 2^i mod A weights, then
// strips multiples of A with an unrolled restoring subtract chain.
module an_residue_mod
  import an_pkg::*;
#(
  parameter int A  = AN_A,
  parameter int CW = AN_CW
) (
  input  logic [CW-1:0]          x_i,
  output logic [$clog2(A)-1:0]   r_o
);

  localparam int RW = $clog2(A);
  localparam int SW = $clog2(CW * (A - 1) + 1);

  logic [SW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < CW; i++) begin
      if (x_i[i]) acc = acc + SW'(pow2_mod(i, A));
    end
    for (int k = SW - 1; k >= 0; k--) begin
      if (int'(acc) >= (A << k)) acc = acc - SW'(A << k);
    end
    r_o = acc[RW-1:0];
  end

endmodule

// File: rtl/an_decoder.sv
// Single 0->1 error-correcting AN decoder (A=13): residue lookup, bit clear,
// exact divide by A, one registered output stage; one word per clock, no back-pressure.
module an_decoder
  import an_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [AN_CW-1:0] ANe,
  output logic             out_valid,
  output logic [AN_DW-1:0] Nc,
  output logic             err_fixed,
  output logic             err_uncorr
);

  logic [AN_RW-1:0] res;
  lut_ent_t         ent;
  logic [AN_CW-1:0] c;
  logic [AN_CW-1:0] rem;
  logic [AN_CW-1:0] quo;
  logic             fix;
  logic             unc;

  logic             out_valid_q;
  logic [AN_DW-1:0] nc_d, nc_q;
  logic             fix_d, fix_q;
  logic             unc_d, unc_q;

  an_residue_mod #(
    .A  (AN_A),
    .CW (AN_CW)
  ) u_residue (
    .x_i (ANe),
    .r_o (res)
  );

  always_comb begin
    ent = AN_LUT[res];
    c   = ANe;
    fix = 1'b0;
    unc = 1'b0;
    // A 0->1 flip can only be undone if the implicated bit is actually set.
    if (res != '0) begin
      if (ent.hit && ANe[ent.pos]) begin
        c[ent.pos] = 1'b0;
        fix        = 1'b1;
      end else begin
        unc = 1'b1;
      end
    end

    rem = c;
    quo = '0;
    for (int k = AN_CW - 1; k >= 0; k--) begin
      if (int'(rem) >= (AN_A << k)) begin
        rem    = rem - AN_CW'(AN_A << k);
        quo[k] = 1'b1;
      end
    end

    nc_d  = quo[AN_DW-1:0];
    fix_d = fix;
    unc_d = unc;
    // Codewords above A*(2^DW-1) are not valid encodings of any data word.
    if (unc || (|quo[AN_CW-1:AN_DW])) begin
      nc_d  = '0;
      fix_d = 1'b0;
      unc_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      nc_q        <= '0;
      fix_q       <= 1'b0;
      unc_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        nc_q  <= nc_d;
        fix_q <= fix_d;
        unc_q <= unc_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign Nc         = nc_q;
  assign err_fixed  = fix_q;
  assign err_uncorr = unc_q;

endmodule

// File: tb/tb_an_decoder.sv
// Directed and exhaustive bench for an_decoder: arithmetic reference model checked every
// cycle, plus literal expectations travelling alongside selected words.
module tb_an_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] ANe;
  logic        out_valid;
  logic [7:0]  Nc;
  logic        err_fixed;
  logic        err_uncorr;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  always #5 clk = ~clk;

  an_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .ANe        (ANe),
    .out_valid  (out_valid),
    .Nc         (Nc),
    .err_fixed  (err_fixed),
    .err_uncorr (err_uncorr)
  );

  // Reference decode straight from the code definition using plain arithmetic.
  function automatic void model(input int ane, output int n, output int f, output int u);
    int r, pos, c;
    r = ane % 13;
    f = 0; u = 0; c = ane; pos = -1;
    if (r != 0) begin
      for (int i = 0; i < 12; i++) if (((1 << i) % 13) == r) pos = i;
      if (pos < 0 || ((ane >> pos) & 1) == 0) u = 1;
      else begin c = ane - (1 << pos); f = 1; end
    end
    n = 0;
    if (u == 0) begin
      n = c / 13;
      if (n > 255) begin n = 0; f = 0; u = 1; end
    end
  endfunction

  int m_vld = 0, m_n = 0, m_f = 0, m_u = 0;

  // Literal expectations attached to the word currently being driven.
  bit lit_en_in = 1'b0;
  int lit_n_in = 0, lit_f_in = 0, lit_u_in = 0;
  bit l_en = 1'b0;
  int l_n = 0, l_f = 0, l_u = 0;

  always @(posedge clk) begin
    int n, f, u;
    model(int'(ANe), n, f, u);
    if (rst) begin
      m_vld <= 0; m_n <= 0; m_f <= 0; m_u <= 0;
      l_en  <= 1'b0;
    end else begin
      m_vld <= int'(in_valid);
      if (in_valid) begin m_n <= n; m_f <= f; m_u <= u; end
      l_en <= in_valid && lit_en_in;
      l_n  <= lit_n_in; l_f <= lit_f_in; l_u <= lit_u_in;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model out_valid", int'(out_valid), m_vld);
      chk("model Nc", int'(Nc), m_n);
      chk("model err_fixed", int'(err_fixed), m_f);
      chk("model err_uncorr", int'(err_uncorr), m_u);
      chk("flags exclusive", int'(err_fixed && err_uncorr), 0);
      if (l_en) begin
        chk("lit out_valid", int'(out_valid), 1);
        chk("lit Nc", int'(Nc), l_n);
        chk("lit err_fixed", int'(err_fixed), l_f);
        chk("lit err_uncorr", int'(err_uncorr), l_u);
      end
    end
  end

  task automatic drive(input int ane, input bit vld, input bit r,
                       input bit le, input int ln, input int lf, input int lu);
    @(negedge clk);
    ANe = 12'(ane); in_valid = vld; rst = r;
    lit_en_in = le; lit_n_in = ln; lit_f_in = lf; lit_u_in = lu;
  endtask

  task automatic word(input int ane, input int ln, input int lf, input int lu);
    drive(ane, 1'b1, 1'b0, 1'b1, ln, lf, lu);
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  int sweep [7] = '{159, 175, 207, 399, 655, 1167, 2191};

  initial begin
    rst = 1'b1; in_valid = 1'b0; ANe = '0;
    drive(0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    drive(0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset Nc", int'(Nc), 0);
    chk("reset err_fixed", int'(err_fixed), 0);
    chk("reset err_uncorr", int'(err_uncorr), 0);
    chk_en = 1'b1;

    idle();
    word(143, 11, 0, 0);
    idle();
    foreach (sweep[k]) word(sweep[k], 11, 1, 0);
    word(0, 0, 0, 0);
    word(3315, 255, 0, 0);
    word(144, 0, 0, 1);
    word(4095, 0, 0, 1);
    idle();
    idle();

    // A word accompanied by reset must vanish, and outputs clear at that edge.
    word(143, 11, 0, 0);
    drive(159, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("rst drop out_valid", int'(out_valid), 0);
    chk("rst drop Nc", int'(Nc), 0);
    chk("rst drop err_fixed", int'(err_fixed), 0);
    rst = 1'b0; in_valid = 1'b0; lit_en_in = 1'b0;
    @(negedge clk);
    chk("post-rst out_valid", int'(out_valid), 0);
    chk("post-rst Nc", int'(Nc), 0);

    for (int n = 0; n < 256; n++) begin
      word(13 * n, n, 0, 0);
      for (int i = 0; i < 12; i++) begin
        if ((((13 * n) >> i) & 1) == 0) word(13 * n + (1 << i), n, 1, 0);
      end
    end
    idle();
    idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
